// File: rtl/alu_32_pkg.sv
// Opcode map and width constants for the registered MIPS execute-stage ALU.
// Extended opcodes are decoded only when ALU_32_EXT_OPS_EN is defined.
package alu_32_pkg;

    localparam int DATA_W = 32;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_SLL  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_SLTU = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_NOR  = 4'd12;

endpackage

// File: rtl/alu_32_addsub.sv
// Combinational 32-bit adder shared by ADD and SUB; subtract inverts b and
// injects a carry-in of one (two's complement).
module alu_32_addsub
    import alu_32_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] sum
);

    logic [DATA_W-1:0] b_eff;
    logic [DATA_W-1:0] carry_in;

    always_comb begin
        b_eff    = b ^ {DATA_W{sub}};
        carry_in = {{(DATA_W-1){1'b0}}, sub};
        sum      = a + b_eff + carry_in;
    end

endmodule

// File: rtl/alu_32.sv
// Registered 32-bit ALU: opcode mux, zero detect and one output register stage.
// Define ALU_32_EXT_OPS_EN to add XOR/SLL/SRL/SLTU/SRA.
module alu_32
    import alu_32_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        ALU_Operation,
    input  logic [DATA_W-1:0] in_left,
    input  logic [DATA_W-1:0] in_right,
    output logic [DATA_W-1:0] ALU_Result,
    output logic              Zero
);

    // No valid/ready: every rising edge accepts a new operation and the
    // result is visible one edge later; there is no backpressure.

    logic [DATA_W-1:0] sum;
    logic              is_sub;
    logic [DATA_W-1:0] result_d, result_q;
    logic              zero_d, zero_q;

    assign is_sub = (ALU_Operation == ALU_SUB);

    alu_32_addsub u_addsub (
        .a   (in_left),
        .b   (in_right),
        .sub (is_sub),
        .sum (sum)
    );

    always_comb begin
        result_d = '0;
        if (!reset) begin
            unique case (ALU_Operation)
                ALU_AND: result_d = in_left & in_right;
                ALU_OR:  result_d = in_left | in_right;
                ALU_ADD: result_d = sum;
                ALU_SUB: result_d = sum;
                // True signed compare so overflowed differences cannot flip the answer.
                ALU_SLT: result_d = ($signed(in_left) < $signed(in_right)) ? 32'd1 : 32'd0;
                ALU_NOR: result_d = ~(in_left | in_right);
`ifdef ALU_32_EXT_OPS_EN
                ALU_XOR:  result_d = in_left ^ in_right;
                ALU_SLL:  result_d = in_left << in_right[4:0];
                ALU_SRL:  result_d = in_left >> in_right[4:0];
                ALU_SLTU: result_d = (in_left < in_right) ? 32'd1 : 32'd0;
                ALU_SRA:  result_d = DATA_W'($signed(in_left) >>> in_right[4:0]);
`endif
                default: result_d = '0;
            endcase
        end
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign ALU_Result = result_q;
    assign Zero       = zero_q;

endmodule

// File: tb/tb_alu_32.sv
// Self-checking bench for alu_32; expected {Zero, ALU_Result} pairs are queued
// when stimulus is driven and popped one edge later. Honours ALU_32_EXT_OPS_EN.
module tb_alu_32;

    logic        clk;
    logic        reset;
    logic [3:0]  ALU_Operation;
    logic [31:0] in_left;
    logic [31:0] in_right;
    logic [31:0] ALU_Result;
    logic        Zero;

    logic [32:0] exp_q[$];
    int          vectors_applied;
    int          miscompares;

    alu_32 dut (
        .clk           (clk),
        .reset         (reset),
        .ALU_Operation (ALU_Operation),
        .in_left       (in_left),
        .in_right      (in_right),
        .ALU_Result    (ALU_Result),
        .Zero          (Zero)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        reset         = 1'b1;
        ALU_Operation = 4'd0;
        in_left       = 32'd0;
        in_right      = 32'd0;
    end

    // Reference behaviour written straight from the opcode table.
    function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic rst);
        logic [31:0] r;
        r = 32'd0;
        if (!rst) begin
            case (op)
                4'd0:  r = a & b;
                4'd1:  r = a | b;
                4'd2:  r = a + b;
                4'd6:  r = a - b;
                4'd7:  r = {31'd0, ($signed(a) < $signed(b))};
                4'd12: r = ~(a | b);
`ifdef ALU_32_EXT_OPS_EN
                4'd3:  r = a ^ b;
                4'd4:  r = a << b[4:0];
                4'd5:  r = a >> b[4:0];
                4'd8:  r = {31'd0, (a < b)};
                4'd9:  r = 32'($signed(a) >>> b[4:0]);
`endif
                default: r = 32'd0;
            endcase
        end
        return {(r == 32'd0), r};
    endfunction

    // Driver: applies inputs on the falling edge, away from the sampling edge.
    task automatic drive(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic rst);
        @(negedge clk);
        reset         = rst;
        ALU_Operation = op;
        in_left       = a;
        in_right      = b;
    endtask

    task automatic test_reset();
        logic [32:0] exp;
        for (int i = 0; i < 2; i++) begin
            drive(4'd0, 32'd3, 32'd5, 1'b1);
            exp_q.push_back({1'b1, 32'd0});
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            vectors_applied++;
            if ({Zero, ALU_Result} !== exp) begin
                miscompares++;
                $display("FAIL reset_hold[%0d]: got zero=%b res=%h, want zero=%b res=%h",
                         i, Zero, ALU_Result, exp[32], exp[31:0]);
            end
        end
        drive(4'd0, 32'd3, 32'd5, 1'b0);
        exp_q.push_back({1'b0, 32'd1});
        @(posedge clk); #1;
        exp = exp_q.pop_front();
        vectors_applied++;
        if ({Zero, ALU_Result} !== exp) begin
            miscompares++;
            $display("FAIL reset_release_and: got zero=%b res=%h, want zero=%b res=%h",
                     Zero, ALU_Result, exp[32], exp[31:0]);
        end
    endtask

    task automatic test_op_sweep();
        logic [3:0]  ops[5]  = '{4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
        logic [31:0] want[5] = '{32'd7, 32'd8, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFF8};
        logic [32:0] exp;
        for (int i = 0; i < 5; i++) begin
            drive(ops[i], 32'd3, 32'd5, 1'b0);
            exp_q.push_back({1'b0, want[i]});
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            vectors_applied++;
            if ({Zero, ALU_Result} !== exp) begin
                miscompares++;
                $display("FAIL sweep_op%0d: got zero=%b res=%h, want zero=%b res=%h",
                         ops[i], Zero, ALU_Result, exp[32], exp[31:0]);
            end
        end
    endtask

    task automatic test_boundaries();
        logic [3:0]  ops[5] = '{4'd6, 4'd2, 4'd7, 4'd7, 4'd15};
        logic [31:0] a[5]   = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hDEAD_BEEF};
        logic [31:0] b[5]   = '{32'd5, 32'd1, 32'd1, 32'h8000_0000, 32'h1234_5678};
        logic [32:0] want[5] = '{{1'b1, 32'd0}, {1'b1, 32'd0}, {1'b0, 32'd1},
                                 {1'b1, 32'd0}, {1'b1, 32'd0}};
        logic [32:0] exp;
        for (int i = 0; i < 5; i++) begin
            drive(ops[i], a[i], b[i], 1'b0);
            exp_q.push_back(want[i]);
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            vectors_applied++;
            if ({Zero, ALU_Result} !== exp) begin
                miscompares++;
                $display("FAIL boundary[%0d] op%0d: got zero=%b res=%h, want zero=%b res=%h",
                         i, ops[i], Zero, ALU_Result, exp[32], exp[31:0]);
            end
        end
    endtask

    task automatic test_ext_ops();
        logic [3:0]  ops[5] = '{4'd4, 4'd9, 4'd3, 4'd5, 4'd8};
        logic [31:0] a[5]   = '{32'd1, 32'h8000_0000, 32'hF0F0_00FF, 32'h8000_0000, 32'd1};
        logic [31:0] b[5]   = '{32'd31, 32'd4, 32'h0FF0_00F0, 32'd4, 32'hFFFF_FFFF};
`ifdef ALU_32_EXT_OPS_EN
        logic [32:0] want[5] = '{{1'b0, 32'h8000_0000}, {1'b0, 32'hF800_0000},
                                 {1'b0, 32'hFF00_000F}, {1'b0, 32'h0800_0000},
                                 {1'b0, 32'd1}};
`else
        logic [32:0] want[5] = '{{1'b1, 32'd0}, {1'b1, 32'd0}, {1'b1, 32'd0},
                                 {1'b1, 32'd0}, {1'b1, 32'd0}};
`endif
        logic [32:0] exp;
        for (int i = 0; i < 5; i++) begin
            drive(ops[i], a[i], b[i], 1'b0);
            exp_q.push_back(want[i]);
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            vectors_applied++;
            if ({Zero, ALU_Result} !== exp) begin
                miscompares++;
                $display("FAIL ext_op%0d: got zero=%b res=%h, want zero=%b res=%h",
                         ops[i], Zero, ALU_Result, exp[32], exp[31:0]);
            end
        end
    endtask

    task automatic test_between_edges();
        logic [32:0] exp;
        drive(4'd2, 32'd1, 32'd2, 1'b0);
        exp_q.push_back({1'b0, 32'd3});
        @(posedge clk); #1;
        exp = exp_q.pop_front();
        vectors_applied++;
        if ({Zero, ALU_Result} !== exp) begin
            miscompares++;
            $display("FAIL hold_first: got zero=%b res=%h, want zero=%b res=%h",
                     Zero, ALU_Result, exp[32], exp[31:0]);
        end
        // Wiggle inputs mid-cycle; outputs must not move until the next edge.
        in_left = 32'd100; ALU_Operation = 4'd0; in_right = 32'd0;
        #1;
        in_left = 32'd7; in_right = 32'd8; ALU_Operation = 4'd2;
        #1;
        vectors_applied++;
        if ({Zero, ALU_Result} !== exp) begin
            miscompares++;
            $display("FAIL hold_mid_cycle: got zero=%b res=%h, want zero=%b res=%h",
                     Zero, ALU_Result, exp[32], exp[31:0]);
        end
        exp_q.push_back({1'b0, 32'd15});
        @(posedge clk); #1;
        exp = exp_q.pop_front();
        vectors_applied++;
        if ({Zero, ALU_Result} !== exp) begin
            miscompares++;
            $display("FAIL hold_next_edge: got zero=%b res=%h, want zero=%b res=%h",
                     Zero, ALU_Result, exp[32], exp[31:0]);
        end
    endtask

    task automatic test_reset_mid_stream();
        logic        rst_seq[3] = '{1'b0, 1'b1, 1'b0};
        logic [32:0] exp;
        for (int i = 0; i < 3; i++) begin
            drive(4'd2, 32'd10, 32'd20, rst_seq[i]);
            exp_q.push_back(rst_seq[i] ? {1'b1, 32'd0} : {1'b0, 32'd30});
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            vectors_applied++;
            if ({Zero, ALU_Result} !== exp) begin
                miscompares++;
                $display("FAIL reset_mid[%0d]: got zero=%b res=%h, want zero=%b res=%h",
                         i, Zero, ALU_Result, exp[32], exp[31:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  op;
        logic [31:0] a, b;
        logic        rst;
        logic [32:0] exp;
        for (int i = 0; i < 60; i++) begin
            op  = 4'($urandom_range(0, 15));
            a   = (i % 7 == 0) ? 32'h8000_0000 : $urandom;
            b   = (i % 5 == 0) ? a : $urandom;
            rst = ($urandom_range(0, 19) == 0);
            drive(op, a, b, rst);
            exp_q.push_back(model(op, a, b, rst));
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            vectors_applied++;
            if ({Zero, ALU_Result} !== exp) begin
                miscompares++;
                $display("FAIL rand[%0d] op%0d a=%h b=%h rst=%b: got zero=%b res=%h, want zero=%b res=%h",
                         i, op, a, b, rst, Zero, ALU_Result, exp[32], exp[31:0]);
            end
        end
    endtask

    initial begin
        vectors_applied = 0;
        miscompares     = 0;
        test_reset();
        test_op_sweep();
        test_boundaries();
        test_ext_ops();
        test_between_edges();
        test_reset_mid_stream();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
